// File: rtl/systolic_pe_param.sv
// systolic_pe_param: one processing element of a parametrised systolic filter.
// Each accepted sample is multiplied by a per-tap coefficient with a bit-serial
// signed shift-add multiplier. The product is rounded and saturated, then
// accumulated over a frame of NTAPS samples. The accumulator restarts on the
// tap selected by phase, and frame_done flags the last tap of each frame.
module systolic_pe_param #(
  parameter int WORDLENGTH = 16,
  parameter int FRACBITS   = 14,
  parameter int NTAPS      = 8,
  parameter int IDXW       = 4
) (
  input  logic                         clk30x,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WORDLENGTH-1:0] inputword,
  input  logic        [IDXW-1:0]       phase,
  input  logic                         coeff_we,
  input  logic        [IDXW-1:0]       coeff_addr,
  input  logic signed [WORDLENGTH-1:0] coeff_data,
  output logic signed [WORDLENGTH-1:0] outputword,
  output logic                         out_valid,
  output logic                         frame_done
);

  localparam int W    = WORDLENGTH;
  localparam int PW   = 2 * WORDLENGTH;
  localparam int CNTW = (W > 1) ? $clog2(W) : 1;

  // Rounding constant (one half LSB of the result) and W-bit limits.
  localparam logic signed [PW-1:0] RND_HALF = PW'(64'd1 << (FRACBITS - 1));
  localparam logic signed [PW-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  WMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  WMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  state_t state, state_nx;

  logic [NTAPS-1:0][W-1:0] coeff;
  logic signed [W-1:0]     coeff_rd;
  logic [IDXW-1:0]         coeff_sel;

  logic [IDXW-1:0]         idx, idx_inc, last_idx;
  logic [IDXW:0]           ph_sum;

  logic signed [PW-1:0]    mcand, prod, prod_rnd, rnd;
  logic [W-1:0]            mplier;
  logic [CNTW-1:0]         cnt;
  logic                    last_bit;

  logic signed [W-1:0]     p, acc, acc_sat;
  logic signed [W:0]       sum;

  logic                    accept, emit, acc_load;

  // State register.
  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; clear always returns to IDLE and aborts any work.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nx = MUL;
        MUL:     if (last_bit) state_nx = ACC;
        ACC:     state_nx = OUT;
        OUT:     state_nx = in_valid ? MUL : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM outputs. OUT also accepts, so a held in_valid gives one sample per
  // WORDLENGTH+2 cycles; that accept reads the coefficient of the next tap.
  always_comb begin
    in_ready  = (state == IDLE) || (state == OUT);
    accept    = in_ready && in_valid && !clear;
    emit      = (state == OUT) && !clear;
    acc_load  = (state == ACC) && !clear;
    coeff_sel = (state == OUT) ? idx_inc : idx;
  end

  // Tap index bookkeeping: wrap-around increment and last tap of the frame.
  always_comb begin
    idx_inc  = (idx == IDXW'(NTAPS - 1)) ? '0 : idx + 1'b1;
    ph_sum   = {1'b0, phase} + (IDXW+1)'(NTAPS - 1);
    last_idx = (ph_sum >= (IDXW+1)'(NTAPS)) ? IDXW'(ph_sum - (IDXW+1)'(NTAPS))
                                              : IDXW'(ph_sum);
  end

  // Coefficient read mux; guarded compare keeps out-of-range indices at zero.
  always_comb begin
    coeff_rd = '0;
    for (int i = 0; i < NTAPS; i++)
      if (coeff_sel == IDXW'(i)) coeff_rd = coeff[i];
  end

  // Coefficient file; writes land at the edge, so a same-edge accept sees the old value.
  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      coeff <= '0;
    end else if (coeff_we) begin
      for (int i = 0; i < NTAPS; i++)
        if (coeff_addr == IDXW'(i)) coeff[i] <= coeff_data;
    end
  end

  assign last_bit = (cnt == CNTW'(W - 1));

  // Bit-serial signed multiplier: one partial product per MUL cycle, LSB
  // first. The sign bit of the multiplier carries weight -2^(W-1), so the last
  // partial product is subtracted, which keeps -2^(W-1) operands exact.
  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= {{W{coeff_rd[W-1]}}, coeff_rd};
      mplier <= inputword;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) prod <= last_bit ? prod - mcand : prod + mcand;
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Round half up, arithmetic shift, saturate product and accumulate sum to W bits.
  always_comb begin
    prod_rnd = prod + RND_HALF;
    rnd      = prod_rnd >>> FRACBITS;
    if (rnd > PMAX)      p = WMAX;
    else if (rnd < PMIN) p = WMIN;
    else                 p = rnd[W-1:0];
    sum = {acc[W-1], acc} + {p[W-1], p};
    if (sum[W] != sum[W-1]) acc_sat = sum[W] ? WMIN : WMAX;
    else                    acc_sat = sum[W-1:0];
  end

  // Accumulator: restarts on the phase tap, otherwise adds with saturation.
  always_ff @(posedge clk30x or posedge reset) begin
    if (reset)         acc <= '0;
    else if (acc_load) acc <= (idx == phase) ? p : acc_sat;
  end

  // Output register, completion pulses and tap index advance.
  always_ff @(posedge clk30x or posedge reset) begin
    if (reset) begin
      outputword <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      idx        <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (emit) begin
        outputword <= acc;
        out_valid  <= 1'b1;
        frame_done <= (idx == last_idx);
        idx        <= idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_param.sv
// Directed bench for systolic_pe_param (W=16, F=14, NTAPS=8).
module tb_systolic_pe_param;

  logic               clk30x = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] inputword = '0;
  logic [3:0]         phase = '0;
  logic               coeff_we = 1'b0;
  logic [3:0]         coeff_addr = '0;
  logic signed [15:0] coeff_data = '0;
  logic signed [15:0] outputword;
  logic               out_valid;
  logic               frame_done;

  int total = 0;
  int bad = 0;

  int EXP_U [8]  = '{100, 201, 303, 406, 510, 615, 721, 828};
  int EXP_P [16] = '{1, 3, 6, 4, 9, 15, 22, 30, 39, 49, 60, 12, 25, 39, 54, 70};

  systolic_pe_param #(.WORDLENGTH(16), .FRACBITS(14), .NTAPS(8), .IDXW(4)) dut (
    .clk30x(clk30x), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .inputword(inputword), .phase(phase),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .outputword(outputword), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk30x = ~clk30x;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic write_coeff(input int a, input int d);
    @(negedge clk30x);
    coeff_we = 1'b1; coeff_addr = 4'(a); coeff_data = 16'(d);
    @(negedge clk30x);
    coeff_we = 1'b0;
  endtask

  task automatic write_all(input int d);
    for (int i = 0; i < 8; i++) write_coeff(i, d);
  endtask

  task automatic do_clear();
    @(negedge clk30x); clear = 1'b1;
    @(negedge clk30x); clear = 1'b0;
  endtask

  // Wait (bounded) for the next out_valid pulse.
  task automatic wait_out(output bit ok, output logic signed [15:0] val, output logic fd);
    ok = 1'b0; val = 'x; fd = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk30x); #1;
      if (out_valid) begin ok = 1'b1; val = outputword; fd = frame_done; break; end
    end
  endtask

  // Offer one sample, wait for its acceptance and its result.
  task automatic send(input int w, output bit ok, output logic signed [15:0] val, output logic fd);
    @(negedge clk30x);
    inputword = 16'(w); in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk30x);
    @(posedge clk30x);
    @(negedge clk30x); in_valid = 1'b0;
    wait_out(ok, val, fd);
  endtask

  task automatic test_reset();
    bit ok; logic signed [15:0] v; logic fd;
    @(negedge clk30x);
    total++; if (outputword !== 16'sd0) begin bad++; $display("FAIL reset_outputword got=%0d exp=0", outputword); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    reset = 1'b0;
    write_coeff(0, 16384);
    send(77, ok, v, fd);
    total++; if (!ok || v !== 16'sd77) begin bad++; $display("FAIL pre_reset_out got=%0d exp=77 ok=%0d", v, ok); end
    // accept a sample, then hit reset asynchronously in the middle of MUL
    @(negedge clk30x); inputword = 16'sd99; in_valid = 1'b1;
    @(posedge clk30x);
    @(negedge clk30x); in_valid = 1'b0;
    repeat (5) @(posedge clk30x);
    #2 reset = 1'b1;
    #1;
    total++; if (outputword !== 16'sd0) begin bad++; $display("FAIL async_reset_outputword got=%0d exp=0", outputword); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid got=%b exp=0", out_valid); end
    @(negedge clk30x); reset = 1'b0;
    send(1234, ok, v, fd);
    total++; if (!ok || v !== 16'sd0) begin bad++; $display("FAIL post_reset_coeff_zero got=%0d exp=0 ok=%0d", v, ok); end
  endtask

  task automatic test_unity();
    bit ok; logic signed [15:0] v; logic fd;
    write_all(16384);
    do_clear();
    phase = 4'd0;
    for (int i = 0; i < 8; i++) begin
      send(100 + i, ok, v, fd);
      total++; if (!ok || v !== 16'(EXP_U[i])) begin bad++; $display("FAIL unity_val[%0d] got=%0d exp=%0d ok=%0d", i, v, EXP_U[i], ok); end
      total++; if (fd !== (i == 7)) begin bad++; $display("FAIL unity_fd[%0d] got=%b exp=%0d", i, fd, (i == 7)); end
    end
    send(108, ok, v, fd);
    total++; if (!ok || v !== 16'sd108) begin bad++; $display("FAIL unity_restart got=%0d exp=108 ok=%0d", v, ok); end
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL unity_restart_fd got=%b exp=0", fd); end
  endtask

  task automatic test_latency();
    int first_ov = -1, second_ov = -1, low_cnt = 0;
    do_clear();
    @(negedge clk30x); inputword = 16'sd1; in_valid = 1'b1;
    @(posedge clk30x);  // accept edge T
    for (int n = 0; n < 40; n++) begin
      #1;
      if (n < 18 && !in_ready) low_cnt++;
      if (out_valid) begin
        if (first_ov < 0) first_ov = n;
        else if (second_ov < 0) second_ov = n;
      end
      @(posedge clk30x);
    end
    @(negedge clk30x); in_valid = 1'b0;
    repeat (25) @(posedge clk30x);
    total++; if (first_ov != 18) begin bad++; $display("FAIL latency_first got=%0d exp=18", first_ov); end
    total++; if (low_cnt != 17) begin bad++; $display("FAIL in_ready_low_cycles got=%0d exp=17", low_cnt); end
    total++; if (second_ov != 36) begin bad++; $display("FAIL back_to_back_second got=%0d exp=36", second_ov); end
  endtask

  task automatic test_round_sat();
    bit ok; logic signed [15:0] v; logic fd;
    int cc [4] = '{8192, 8192, 32767, -32768};
    int xx [4] = '{3, -3, 30000, -32768};
    int ee [4] = '{2, -1, 32767, 32767};
    phase = 4'd0;
    for (int i = 0; i < 4; i++) begin
      write_coeff(0, cc[i]);
      do_clear();
      send(xx[i], ok, v, fd);
      total++; if (!ok || v !== 16'(ee[i])) begin bad++; $display("FAIL round_sat[%0d] got=%0d exp=%0d ok=%0d", i, v, ee[i], ok); end
    end
    write_coeff(0, -16384);
    write_coeff(1, -16384);
    do_clear();
    send(20000, ok, v, fd);
    total++; if (!ok || v !== -16'sd20000) begin bad++; $display("FAIL neg_product got=%0d exp=-20000 ok=%0d", v, ok); end
    send(20000, ok, v, fd);
    total++; if (!ok || v !== -16'sd32768) begin bad++; $display("FAIL acc_neg_sat got=%0d exp=-32768 ok=%0d", v, ok); end
  endtask

  task automatic test_phase();
    bit ok; logic signed [15:0] v; logic fd;
    write_all(16384);
    do_clear();
    phase = 4'd0;
    send(0, ok, v, fd);  // brings the accumulator to zero
    total++; if (!ok || v !== 16'sd0) begin bad++; $display("FAIL phase_zero_acc got=%0d exp=0 ok=%0d", v, ok); end
    do_clear();
    phase = 4'd3;
    for (int i = 0; i < 16; i++) begin
      send(i + 1, ok, v, fd);
      total++; if (!ok || v !== 16'(EXP_P[i])) begin bad++; $display("FAIL phase_val[%0d] got=%0d exp=%0d ok=%0d", i, v, EXP_P[i], ok); end
      total++; if (fd !== (i == 2 || i == 10)) begin bad++; $display("FAIL phase_fd[%0d] got=%b exp=%0d", i, fd, (i == 2 || i == 10)); end
    end
    phase = 4'd0;
  endtask

  task automatic test_collision();
    bit ok; logic signed [15:0] v; logic fd;
    do_clear();
    @(negedge clk30x);
    inputword = 16'sd50; in_valid = 1'b1;
    coeff_we = 1'b1; coeff_addr = 4'd0; coeff_data = 16'sd0;
    @(posedge clk30x);
    @(negedge clk30x); in_valid = 1'b0; coeff_we = 1'b0;
    wait_out(ok, v, fd);
    total++; if (!ok || v !== 16'sd50) begin bad++; $display("FAIL collision_old_coeff got=%0d exp=50 ok=%0d", v, ok); end
    do_clear();
    send(50, ok, v, fd);
    total++; if (!ok || v !== 16'sd0) begin bad++; $display("FAIL collision_new_coeff got=%0d exp=0 ok=%0d", v, ok); end
    write_coeff(0, 16384);
  endtask

  task automatic test_clear();
    bit ok; logic signed [15:0] v; logic fd;
    int ov_cnt = 0;
    do_clear();
    send(10, ok, v, fd);
    total++; if (!ok || v !== 16'sd10) begin bad++; $display("FAIL clear_pre got=%0d exp=10 ok=%0d", v, ok); end
    @(negedge clk30x); inputword = 16'sd7; in_valid = 1'b1;
    @(posedge clk30x);
    @(negedge clk30x); in_valid = 1'b0;
    repeat (5) @(posedge clk30x);
    @(negedge clk30x); clear = 1'b1;
    @(posedge clk30x); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clear_in_ready got=%b exp=1", in_ready); end
    @(negedge clk30x); clear = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk30x); #1;
      if (out_valid) ov_cnt++;
    end
    total++; if (ov_cnt != 0) begin bad++; $display("FAIL clear_abort_out_valid got=%0d exp=0", ov_cnt); end
    // clear and in_valid together in IDLE: no accept
    @(negedge clk30x); clear = 1'b1; in_valid = 1'b1; inputword = 16'sd9;
    @(posedge clk30x); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clear_wins_in_ready got=%b exp=1", in_ready); end
    @(negedge clk30x); clear = 1'b0; in_valid = 1'b0;
    send(5, ok, v, fd);
    total++; if (!ok || v !== 16'sd5) begin bad++; $display("FAIL clear_idx_zero got=%0d exp=5 ok=%0d", v, ok); end
  endtask

  initial begin
    repeat (3) @(posedge clk30x);
    test_reset();
    test_unity();
    test_latency();
    test_round_sat();
    test_phase();
    test_collision();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
